// File: rtl/secuenciador_inicializacion.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : secuenciador_inicializacion
// Description : Steps the RTC init decoder through N_REG register writes and
//               generates cs_n/wr_n/rd_n strobes with programmable timing.
// Revision    : 1.0 - initial release
// ============================================================================
module secuenciador_inicializacion #(
    parameter int N_REG   = 5,
    parameter int T_SETUP = 2,
    parameter int T_PULSO = 4,
    parameter int T_HOLD  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic       abortar,
    output logic [2:0] cuenta,
    output logic       a_d,
    output logic       c_s,
    output logic       en_deco,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       ocupado,
    output logic       listo
);

    typedef enum logic [3:0] {
        S_REPOSO     = 4'd0,
        S_PREP_DIR   = 4'd1,
        S_PULSO_DIR  = 4'd2,
        S_ESPERA_DIR = 4'd3,
        S_PREP_DAT   = 4'd4,
        S_PULSO_DAT  = 4'd5,
        S_ESPERA_DAT = 4'd6,
        S_SIGUIENTE  = 4'd7,
        S_FIN        = 4'd8
    } estado_t;

    localparam logic [3:0] c_carga_setup = 4'(T_SETUP - 1);
    localparam logic [3:0] c_carga_pulso = 4'(T_PULSO - 1);
    localparam logic [3:0] c_carga_hold  = 4'(T_HOLD - 1);
    localparam logic [2:0] c_ultimo      = 3'(N_REG - 1);

    estado_t    r_estado, w_estado_sig;
    logic [3:0] r_timer, w_timer_sig;
    logic [2:0] r_cuenta, w_cuenta_sig;
    logic       r_abort, w_abort_sig;
    logic       w_tfin, w_abort_pend, w_ir_reposo;

    logic r_a_d, r_c_s, r_en_deco, r_cs_n, r_wr_n, r_ocupado, r_listo;
    logic w_a_d, w_c_s, w_en_deco, w_cs_n, w_wr_n, w_ocupado, w_listo;

    assign w_tfin       = (r_timer == 4'd0);
    assign w_abort_pend = r_abort | abortar;

    always_comb begin
        w_estado_sig = r_estado;
        w_timer_sig  = r_timer;
        w_cuenta_sig = r_cuenta;
        w_abort_sig  = r_abort;
        w_ir_reposo  = 1'b0;
        case (r_estado)
            S_REPOSO, S_FIN: begin
                if (iniciar && !abortar) begin
                    w_estado_sig = S_PREP_DIR;
                    w_timer_sig  = c_carga_setup;
                    w_cuenta_sig = 3'd0;
                    w_abort_sig  = 1'b0;
                end
            end
            S_PREP_DIR, S_PREP_DAT: begin
                if (abortar) begin
                    w_ir_reposo = 1'b1;
                end else if (w_tfin) begin
                    w_estado_sig = (r_estado == S_PREP_DIR) ? S_PULSO_DIR : S_PULSO_DAT;
                    w_timer_sig  = c_carga_pulso;
                end else begin
                    w_timer_sig = r_timer - 4'd1;
                end
            end
            // An abort here is only remembered: the strobe and hold always finish.
            S_PULSO_DIR, S_PULSO_DAT: begin
                w_abort_sig = w_abort_pend;
                if (w_tfin) begin
                    w_estado_sig = (r_estado == S_PULSO_DIR) ? S_ESPERA_DIR : S_ESPERA_DAT;
                    w_timer_sig  = c_carga_hold;
                end else begin
                    w_timer_sig = r_timer - 4'd1;
                end
            end
            S_ESPERA_DIR, S_ESPERA_DAT: begin
                w_abort_sig = w_abort_pend;
                if (w_tfin) begin
                    if (w_abort_pend) begin
                        w_ir_reposo = 1'b1;
                    end else if (r_estado == S_ESPERA_DIR) begin
                        w_estado_sig = S_PREP_DAT;
                        w_timer_sig  = c_carga_setup;
                    end else begin
                        w_estado_sig = S_SIGUIENTE;
                        w_timer_sig  = 4'd0;
                    end
                end else begin
                    w_timer_sig = r_timer - 4'd1;
                end
            end
            S_SIGUIENTE: begin
                if (abortar) begin
                    w_ir_reposo = 1'b1;
                end else if (r_cuenta == c_ultimo) begin
                    w_estado_sig = S_FIN;
                end else begin
                    w_estado_sig = S_PREP_DIR;
                    w_timer_sig  = c_carga_setup;
                    w_cuenta_sig = r_cuenta + 3'd1;
                end
            end
            default: begin
                w_ir_reposo = 1'b1;
            end
        endcase
        if (w_ir_reposo) begin
            w_estado_sig = S_REPOSO;
            w_timer_sig  = 4'd0;
            w_cuenta_sig = 3'd0;
            w_abort_sig  = 1'b0;
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with it.
    always_comb begin
        w_a_d     = 1'b0;
        w_c_s     = 1'b0;
        w_en_deco = 1'b1;
        w_cs_n    = 1'b1;
        w_wr_n    = 1'b1;
        w_ocupado = 1'b0;
        w_listo   = 1'b0;
        case (w_estado_sig)
            S_PREP_DIR, S_PREP_DAT: begin
                w_a_d     = (w_estado_sig == S_PREP_DAT);
                w_en_deco = 1'b0;
                w_cs_n    = 1'b0;
                w_ocupado = 1'b1;
            end
            S_PULSO_DIR, S_PULSO_DAT: begin
                w_a_d     = (w_estado_sig == S_PULSO_DAT);
                w_c_s     = 1'b1;
                w_en_deco = 1'b0;
                w_cs_n    = 1'b0;
                w_wr_n    = 1'b0;
                w_ocupado = 1'b1;
            end
            S_ESPERA_DIR, S_ESPERA_DAT: begin
                w_a_d     = (w_estado_sig == S_ESPERA_DAT);
                w_c_s     = 1'b1;
                w_en_deco = 1'b0;
                w_cs_n    = 1'b0;
                w_ocupado = 1'b1;
            end
            S_SIGUIENTE: begin
                w_a_d     = 1'b1;
                w_en_deco = 1'b0;
                w_ocupado = 1'b1;
            end
            S_FIN: begin
                w_listo = 1'b1;
            end
            default: begin
                w_listo = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_estado  <= S_REPOSO;
            r_timer   <= 4'd0;
            r_cuenta  <= 3'd0;
            r_abort   <= 1'b0;
            r_a_d     <= 1'b0;
            r_c_s     <= 1'b0;
            r_en_deco <= 1'b1;
            r_cs_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_ocupado <= 1'b0;
            r_listo   <= 1'b0;
        end else begin
            r_estado  <= w_estado_sig;
            r_timer   <= w_timer_sig;
            r_cuenta  <= w_cuenta_sig;
            r_abort   <= w_abort_sig;
            r_a_d     <= w_a_d;
            r_c_s     <= w_c_s;
            r_en_deco <= w_en_deco;
            r_cs_n    <= w_cs_n;
            r_wr_n    <= w_wr_n;
            r_ocupado <= w_ocupado;
            r_listo   <= w_listo;
        end
    end

    assign cuenta  = r_cuenta;
    assign a_d     = r_a_d;
    assign c_s     = r_c_s;
    assign en_deco = r_en_deco;
    assign cs_n    = r_cs_n;
    assign wr_n    = r_wr_n;
    assign rd_n    = 1'b1;
    assign ocupado = r_ocupado;
    assign listo   = r_listo;

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_inicializacion.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_secuenciador_inicializacion
// Description : Randomized bench comparing two configurations of the init
//               sequencer against a cycle-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_secuenciador_inicializacion;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ini1 = 1'b0, ab1 = 1'b0, ini2 = 1'b0, ab2 = 1'b0;

    logic [2:0] cuenta1, cuenta2;
    logic a_d1, c_s1, en1, csn1, wrn1, rdn1, oc1, li1;
    logic a_d2, c_s2, en2, csn2, wrn2, rdn2, oc2, li2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    secuenciador_inicializacion u_dut1 (
        .clk(clk), .reset_n(reset_n), .iniciar(ini1), .abortar(ab1),
        .cuenta(cuenta1), .a_d(a_d1), .c_s(c_s1), .en_deco(en1), .cs_n(csn1),
        .wr_n(wrn1), .rd_n(rdn1), .ocupado(oc1), .listo(li1)
    );

    secuenciador_inicializacion #(.N_REG(2), .T_SETUP(1), .T_PULSO(1), .T_HOLD(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .iniciar(ini2), .abortar(ab2),
        .cuenta(cuenta2), .a_d(a_d2), .c_s(c_s2), .en_deco(en2), .cs_n(csn2),
        .wr_n(wrn2), .rd_n(rdn2), .ocupado(oc2), .listo(li2)
    );

    // Model: idle / running at cycle t of the sequence / finished.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_FIN  = 2;
    typedef struct {
        int mode;
        int t;
        int abort_end;
    } mdl_t;

    mdl_t m1, m2;

    function automatic mdl_t model_step(mdl_t m, logic ini, logic ab, int n, int ts, int tp, int th);
        mdl_t r;
        int   ph, l, o, q;
        r  = m;
        ph = ts + tp + th;
        l  = 2 * ph + 1;
        if (m.mode != M_RUN) begin
            if (ini && !ab) begin
                r.mode = M_RUN; r.t = 0; r.abort_end = -1;
            end
            return r;
        end
        o = m.t % l;
        if (ab && m.abort_end < 0) begin
            if (o == 2 * ph) begin
                r.mode = M_IDLE; return r;
            end
            q = o % ph;
            if (q < ts) begin
                r.mode = M_IDLE; return r;
            end
            r.abort_end = m.t - q + ph - 1;
        end
        if (r.abort_end >= 0 && m.t == r.abort_end) begin
            r.mode = M_IDLE; return r;
        end
        r.t = m.t + 1;
        if (r.t == n * l) r.mode = M_FIN;
        return r;
    endfunction

    // Returns {mask, expected}; bit order {cuenta, a_d, c_s, en_deco, cs_n, wr_n, rd_n, ocupado, listo}.
    function automatic logic [21:0] model_exp(mdl_t m, int ts, int tp, int th);
        int         ph, l, k, o, q;
        logic [10:0] e, mk;
        ph = ts + tp + th;
        l  = 2 * ph + 1;
        mk = 11'h7FF;
        e  = 11'b000_0_0_1_1_1_1_0_0;
        if (m.mode == M_FIN) begin
            mk = 11'b000_0_0_1_1_1_1_1_1;
            e  = 11'b000_0_0_1_1_1_1_0_1;
        end else if (m.mode == M_RUN) begin
            k = m.t / l;
            o = m.t % l;
            if (o == 2 * ph) begin
                mk = 11'b111_0_1_0_1_1_1_1_1;
                e  = {3'(k), 8'b0_0_0_1_1_1_1_0};
            end else begin
                q = o % ph;
                e = {3'(k), (o >= ph) ? 1'b1 : 1'b0, (q >= ts) ? 1'b1 : 1'b0, 1'b0, 1'b0,
                     (q >= ts && q < ts + tp) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0};
            end
        end
        return {mk, e & mk};
    endfunction

    function automatic logic [10:0] obs1();
        return {cuenta1, a_d1, c_s1, en1, csn1, wrn1, rdn1, oc1, li1};
    endfunction

    function automatic logic [10:0] obs2();
        return {cuenta2, a_d2, c_s2, en2, csn2, wrn2, rdn2, oc2, li2};
    endfunction

    task automatic test_reset();
        logic [21:0] e;
        ini1 = 1'b0; ab1 = 1'b0; ini2 = 1'b0; ab2 = 1'b0;
        reset_n = 1'b0;
        m1 = '{M_IDLE, 0, -1};
        m2 = '{M_IDLE, 0, -1};
        @(negedge clk);
        e = model_exp(m1, 2, 4, 2);
        n_tests++;
        if ((obs1() & e[21:11]) !== e[10:0]) begin
            n_fail++;
            $display("FAIL reset_values: outputs %b, required %b", obs1(), e[10:0]);
        end
        reset_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            e = model_exp(m2, 1, 1, 1);
            n_tests++;
            if ((obs2() & e[21:11]) !== e[10:0]) begin
                n_fail++;
                $display("FAIL reset_idle2 cycle %0d: outputs %b, required %b", c, obs2(), e[10:0]);
            end
        end
    endtask

    task automatic test_full_sequence();
        logic [21:0] e;
        int   n_oc = 0, n_fall = 0, first_li = -1, n_inv = 0, n_gap = 0;
        logic prev_wr = 1'b1;
        for (int c = 1; c <= 95; c++) begin
            ini1 = (c == 1); ab1 = 1'b0;
            @(posedge clk);
            m1 = model_step(m1, ini1, ab1, 5, 2, 4, 2);
            @(negedge clk);
            e = model_exp(m1, 2, 4, 2);
            n_tests++;
            if ((obs1() & e[21:11]) !== e[10:0]) begin
                n_fail++;
                $display("FAIL full_seq edge %0d: outputs %b, required %b mask %b", c, obs1(), e[10:0], e[21:11]);
            end
            if (oc1) n_oc++;
            if (prev_wr && !wrn1) n_fall++;
            prev_wr = wrn1;
            if (li1 && first_li < 0) first_li = c;
            if (!wrn1 && !(c_s1 && !csn1)) n_inv++;
            if (oc1 && csn1) n_gap++;
        end
        ini1 = 1'b0;
        n_tests++;
        if (n_oc !== 85) begin n_fail++; $display("FAIL ocupado_cycles: got %0d, required 85", n_oc); end
        n_tests++;
        if (n_fall !== 10) begin n_fail++; $display("FAIL wr_falls: got %0d, required 10", n_fall); end
        n_tests++;
        if (first_li !== 86) begin n_fail++; $display("FAIL listo_edge: got %0d, required 86", first_li); end
        n_tests++;
        if (n_inv !== 0) begin n_fail++; $display("FAIL strobe_invariant: %0d violations, required 0", n_inv); end
        n_tests++;
        if (n_gap !== 5) begin n_fail++; $display("FAIL cs_gap_cycles: got %0d, required 5", n_gap); end
    endtask

    task automatic test_abort();
        logic [21:0] e;
        int   wr_rise = -1, idle_at = -1, n_ad = 0, n_li = 0;
        logic seen_low = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            ini1 = (c == 1); ab1 = (c == 5);
            @(posedge clk);
            m1 = model_step(m1, ini1, ab1, 5, 2, 4, 2);
            @(negedge clk);
            e = model_exp(m1, 2, 4, 2);
            n_tests++;
            if ((obs1() & e[21:11]) !== e[10:0]) begin
                n_fail++;
                $display("FAIL abort edge %0d: outputs %b, required %b mask %b", c, obs1(), e[10:0], e[21:11]);
            end
            if (!wrn1) seen_low = 1'b1;
            if (seen_low && wrn1 && wr_rise < 0) wr_rise = c;
            if (c > 1 && !oc1 && idle_at < 0) idle_at = c;
            if (a_d1) n_ad++;
            if (li1) n_li++;
        end
        ab1 = 1'b0; ini1 = 1'b0;
        n_tests++;
        if (wr_rise !== 7) begin n_fail++; $display("FAIL abort_wr_rise: edge %0d, required 7", wr_rise); end
        n_tests++;
        if (idle_at !== 9) begin n_fail++; $display("FAIL abort_reposo: edge %0d, required 9", idle_at); end
        n_tests++;
        if (n_ad !== 0 || n_li !== 0) begin
            n_fail++; $display("FAIL abort_no_data: a_d cycles %0d listo cycles %0d, required 0 0", n_ad, n_li);
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] e;
        int n_oc = 0;
        for (int c = 1; c <= 180; c++) begin
            ini1 = (c == 1) || (c == 90) ||
                   ((((c > 1) && (c < 85)) || ((c > 90) && (c < 170))) && ($urandom_range(0, 3) == 0));
            ab1 = 1'b0;
            @(posedge clk);
            m1 = model_step(m1, ini1, ab1, 5, 2, 4, 2);
            @(negedge clk);
            e = model_exp(m1, 2, 4, 2);
            n_tests++;
            if ((obs1() & e[21:11]) !== e[10:0]) begin
                n_fail++;
                $display("FAIL back_to_back edge %0d: outputs %b, required %b mask %b", c, obs1(), e[10:0], e[21:11]);
            end
            if (oc1) n_oc++;
            if (c == 89) begin
                n_tests++;
                if (li1 !== 1'b1) begin n_fail++; $display("FAIL fin_listo: listo %b, required 1", li1); end
            end
            if (c == 90) begin
                n_tests++;
                if (li1 !== 1'b0) begin n_fail++; $display("FAIL restart_listo: listo %b, required 0", li1); end
            end
        end
        ini1 = 1'b0;
        n_tests++;
        if (n_oc !== 170) begin n_fail++; $display("FAIL back_to_back_ocupado: got %0d, required 170", n_oc); end
    endtask

    task automatic test_reset_mid();
        logic [21:0] e;
        for (int c = 1; c <= 12; c++) begin
            ini1 = (c == 1); ab1 = 1'b0;
            @(posedge clk);
            m1 = model_step(m1, ini1, ab1, 5, 2, 4, 2);
            @(negedge clk);
            e = model_exp(m1, 2, 4, 2);
            n_tests++;
            if ((obs1() & e[21:11]) !== e[10:0]) begin
                n_fail++;
                $display("FAIL reset_mid_run edge %0d: outputs %b, required %b", c, obs1(), e[10:0]);
            end
        end
        ini1 = 1'b0;
        n_tests++;
        if (wrn1 !== 1'b0 || a_d1 !== 1'b1) begin
            n_fail++; $display("FAIL pulso_dat_reached: wr_n %b a_d %b, required 0 1", wrn1, a_d1);
        end
        #2 reset_n = 1'b0;
        #1;
        m1 = '{M_IDLE, 0, -1};
        m2 = '{M_IDLE, 0, -1};
        e = model_exp(m1, 2, 4, 2);
        n_tests++;
        if ((obs1() & e[21:11]) !== e[10:0]) begin
            n_fail++; $display("FAIL async_reset: outputs %b, required %b", obs1(), e[10:0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            m1 = model_step(m1, ini1, ab1, 5, 2, 4, 2);
            @(negedge clk);
            e = model_exp(m1, 2, 4, 2);
            n_tests++;
            if ((obs1() & e[21:11]) !== e[10:0]) begin
                n_fail++; $display("FAIL post_reset_idle cycle %0d: outputs %b, required %b", c, obs1(), e[10:0]);
            end
        end
    endtask

    task automatic test_small_params();
        logic [21:0] e;
        int   first_li = -1, n_oc = 0, n_bad = 0;
        logic saw_one = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            ini2 = (c == 1); ab2 = 1'b0;
            @(posedge clk);
            m2 = model_step(m2, ini2, ab2, 2, 1, 1, 1);
            @(negedge clk);
            e = model_exp(m2, 1, 1, 1);
            n_tests++;
            if ((obs2() & e[21:11]) !== e[10:0]) begin
                n_fail++;
                $display("FAIL small_params edge %0d: outputs %b, required %b mask %b", c, obs2(), e[10:0], e[21:11]);
            end
            if (oc2) n_oc++;
            if (li2 && first_li < 0) first_li = c;
            if (oc2 && cuenta2 > 3'd1) n_bad++;
            if (oc2 && cuenta2 == 3'd1) saw_one = 1'b1;
        end
        ini2 = 1'b0;
        n_tests++;
        if (first_li !== 15) begin n_fail++; $display("FAIL small_listo_edge: got %0d, required 15", first_li); end
        n_tests++;
        if (n_oc !== 14) begin n_fail++; $display("FAIL small_ocupado: got %0d, required 14", n_oc); end
        n_tests++;
        if (n_bad !== 0 || saw_one !== 1'b1) begin
            n_fail++; $display("FAIL small_cuenta_range: out-of-range %0d saw1 %b, required 0 1", n_bad, saw_one);
        end
    endtask

    task automatic test_random();
        logic [21:0] e;
        for (int c = 1; c <= 2000; c++) begin
            ini1 = ($urandom_range(0, 7) == 0);
            ab1  = ($urandom_range(0, 29) == 0);
            ini2 = ($urandom_range(0, 5) == 0);
            ab2  = ($urandom_range(0, 19) == 0);
            @(posedge clk);
            m1 = model_step(m1, ini1, ab1, 5, 2, 4, 2);
            m2 = model_step(m2, ini2, ab2, 2, 1, 1, 1);
            @(negedge clk);
            e = model_exp(m1, 2, 4, 2);
            n_tests++;
            if ((obs1() & e[21:11]) !== e[10:0]) begin
                n_fail++;
                $display("FAIL random1 cycle %0d: outputs %b, required %b mask %b", c, obs1(), e[10:0], e[21:11]);
            end
            e = model_exp(m2, 1, 1, 1);
            n_tests++;
            if ((obs2() & e[21:11]) !== e[10:0]) begin
                n_fail++;
                $display("FAIL random2 cycle %0d: outputs %b, required %b mask %b", c, obs2(), e[10:0], e[21:11]);
            end
        end
        ini1 = 1'b0; ab1 = 1'b0; ini2 = 1'b0; ab2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_small_params();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
